teller_dispatcher: RTL and testbench
====================================

TELLER_DISPATCHER -- requirements
Module: teller_dispatcher

Interface
REQ-001 The block SHALL have parameter QDEPTH, default 7: ticket queue depth; count width 3 bits.
REQ-002 The block SHALL have parameter TICKET_W, default 4: ticket number width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port arrive, input, 1 bit: customer-arrival button, level.
REQ-006 The block SHALL have port done, input, 3 bits: per-teller service-complete buttons, level.
REQ-007 The block SHALL have port teller_en, input, 3 bits: per-teller on-duty enables.
REQ-008 The block SHALL have port q_count, output, 3 bits: customers waiting.
REQ-009 The block SHALL have ports full and empty, outputs, 1 bit each: queue status flags.
REQ-010 The block SHALL have port busy, output, 3 bits: per-teller serving flags.
REQ-011 The block SHALL have port call_valid, output, 1 bit: one-cycle pulse marking a new call.
REQ-012 The block SHALL have port call_teller, output, 2 bits: index (0-2) of the teller called.
REQ-013 The block SHALL have port call_ticket, output, TICKET_W bits: ticket number called.
REQ-014 The block SHALL have port reject, output, 1 bit: one-cycle pulse on an arrival dropped because the queue was full.
REQ-015 The block SHALL have port est_wait, output, 5 bits: estimated wait in minutes.

Function
REQ-016 Edge detection SHALL register arrive and done every cycle; an event SHALL be input high while its registered copy is low; held levels SHALL give one event.
REQ-017 Tickets SHALL be numbered from 1, incremented per accepted arrival, wrapping 15->1; 0 SHALL never be issued.
REQ-018 An arrival event while not full SHALL enqueue the next ticket at that edge, incrementing q_count.
REQ-019 An arrival event while full SHALL drop the ticket, pulse reject for 1 cycle, and leave the ticket counter and queue unchanged.
REQ-020 The queue FSM SHALL have states EMPTY, ACTIVE and FULL; empty=1 only in EMPTY and full=1 only in FULL, both registered.
REQ-021 Queue FSM transitions SHALL be EMPTY->ACTIVE on enqueue, ACTIVE->FULL when count reaches QDEPTH, ACTIVE->EMPTY when count reaches 0, and FULL->ACTIVE on pop.
REQ-022 A teller SHALL be eligible when teller_en=1 and busy=0, using the state before the edge.
REQ-023 Dispatch SHALL occur when queue is non-empty and at least one teller is eligible, at most one per cycle.
REQ-024 On dispatch, the queue head SHALL be popped, the chosen teller's busy flag set, call_valid pulsed for 1 cycle, and call_teller/call_ticket loaded and held until the next dispatch.
REQ-025 Teller choice SHALL be round-robin, searching from last-granted+1 mod 3.
REQ-026 Dispatch latency SHALL have no bypass: an arrival accepted at edge k is dispatched no earlier than edge k+1.
REQ-027 On a simultaneous enqueue and dispatch, both SHALL happen, q_count SHALL be unchanged, and so SHALL the FSM state (FULL SHALL stay FULL).
REQ-028 A done event SHALL clear that teller's busy flag at the edge; a freed teller SHALL be eligible from the next cycle; done on a non-busy teller SHALL be ignored.
REQ-029 Deasserting teller_en on a busy teller SHALL NOT clear busy; that teller SHALL receive no further grants.
REQ-030 est_wait SHALL be registered and equal q_count x S, where S=3 for one enabled teller, 2 for two, 1 for three.
REQ-031 When no teller is enabled, est_wait SHALL be 0 if the queue is empty and 31 otherwise.
REQ-032 est_wait SHALL lag q_count by 1 cycle.

Reset
REQ-033 With reset=0 at a clock edge: queue pointers/count=0, state EMPTY, empty=1, full=0, busy=0, call_valid=0, call_teller=0, call_ticket=0, reject=0, est_wait=0, next ticket=1, last-granted=2 (first grant to teller 0), edge registers=0.
REQ-034 A reset mid-operation SHALL discard all queued tickets and busy flags in that cycle, with no call_valid or reject pulse.

Structure
REQ-035 A shared package SHALL hold QDEPTH, TICKET_W, N_TELLER=3, the queue-state encodings and the service-time table.
REQ-036 The queue storage SHALL be one sub-module, ticket_fifo (push, pop, head, count); the arbiter, edge detection and FSM SHALL be in the top.

Verification
REQ-037 Bench SHALL cover: reset, teller_en=001, 3 arrival pulses -> tickets 1,2,3 queued; ticket 1 called to teller 0 one cycle after its arrival; q_count=2 then, est_wait=6 one cycle later.
REQ-038 Bench SHALL cover: teller_en=000, 8 arrivals -> q_count=7, full=1, 8th gives reject pulse, est_wait=31.
REQ-039 Bench SHALL cover: teller_en=111, queue of 4 -> call_teller 0,1,2 on consecutive cycles; a 4th call waits until a done, then goes to the freed teller.
REQ-040 Bench SHALL cover: full queue with simultaneous arrival edge and dispatch -> q_count stays 7, full stays 1, no reject.
REQ-041 Bench SHALL cover: 16 accept/dispatch cycles -> call_ticket sequence 1..15,1 (0 skipped).
REQ-042 Bench SHALL cover: reset=0 asserted with q_count=5, busy=011 -> next cycle q_count=0, empty=1, busy=000, next ticket=1.

Source files
------------

// File: rtl/teller_dispatcher_pkg.sv
// Shared constants, queue-state encoding and the service-time table for the teller dispatcher.
package teller_dispatcher_pkg;

  localparam int QDEPTH   = 7;
  localparam int TICKET_W = 4;
  localparam int N_TELLER = 3;
  localparam int CNT_W    = 3;
  localparam int EST_W    = 5;

  typedef enum logic [1:0] {
    Q_EMPTY  = 2'd0,
    Q_ACTIVE = 2'd1,
    Q_FULL   = 2'd2
  } qstate_t;

  // Minutes per waiting customer, indexed by the number of tellers on duty.
  localparam logic [1:0] SVC_MIN [4] = '{2'd0, 2'd3, 2'd2, 2'd1};

  function automatic logic [1:0] next_teller(input logic [1:0] t);
    return (t == 2'd2) ? 2'd0 : t + 2'd1;
  endfunction

  function automatic logic [EST_W-1:0] est_calc(input logic [CNT_W-1:0]    cnt,
                                                input logic [N_TELLER-1:0] en);
    logic [1:0] n;
    n = {1'b0, en[0]} + {1'b0, en[1]} + {1'b0, en[2]};
    if (n == 2'd0) return (cnt == '0) ? '0 : '1;
    return EST_W'(cnt) * EST_W'(SVC_MIN[n]);
  endfunction

endpackage

// File: rtl/teller_dispatcher_if.sv
// Customer/teller signal bundle between the dispatcher and its environment.
interface teller_dispatcher_if #(
  parameter int TICKET_W = teller_dispatcher_pkg::TICKET_W
);
  logic                arrive;
  logic [2:0]          done;
  logic [2:0]          teller_en;
  logic [2:0]          q_count;
  logic                full;
  logic                empty;
  logic [2:0]          busy;
  logic                call_valid;
  logic [1:0]          call_teller;
  logic [TICKET_W-1:0] call_ticket;
  logic                reject;
  logic [4:0]          est_wait;

  modport master (
    output arrive, done, teller_en,
    input  q_count, full, empty, busy, call_valid, call_teller, call_ticket, reject, est_wait
  );

  modport slave (
    input  arrive, done, teller_en,
    output q_count, full, empty, busy, call_valid, call_teller, call_ticket, reject, est_wait
  );
endinterface

// File: rtl/teller_dispatcher_ticket_fifo.sv
// Circular ticket store; push and pop in the same cycle are allowed even when full.
module ticket_fifo #(
  parameter int DEPTH = 7,
  parameter int W     = 4
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [W-1:0]                 i_data,
  output logic [W-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= ptr_inc(r_wr);
      if (i_pop)  r_rd <= ptr_inc(r_rd);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/teller_dispatcher.sv
// Bank ticket dispatcher: edge-detects arrivals/completions, queues tickets and
// hands the queue head to on-duty tellers in round-robin order.
module teller_dispatcher #(
  parameter int QDEPTH   = teller_dispatcher_pkg::QDEPTH,
  parameter int TICKET_W = teller_dispatcher_pkg::TICKET_W
) (
  input logic                clk,
  input logic                reset,
  teller_dispatcher_if.slave bus
);
  import teller_dispatcher_pkg::*;

  logic                r_arrive_d;
  logic [N_TELLER-1:0] r_done_d;
  qstate_t             r_state;
  qstate_t             w_state_n;
  logic                r_empty;
  logic                r_full;
  logic [N_TELLER-1:0] r_busy;
  logic [1:0]          r_last;
  logic                r_call_valid;
  logic [1:0]          r_call_teller;
  logic [TICKET_W-1:0] r_call_ticket;
  logic                r_reject;
  logic [TICKET_W-1:0] r_next_tkt;
  logic [EST_W-1:0]    r_est;

  logic                w_arrive_ev;
  logic [N_TELLER-1:0] w_done_ev;
  logic [N_TELLER-1:0] w_elig;
  logic [1:0]          w_c0, w_c1, w_c2;
  logic                w_gnt_vld;
  logic [1:0]          w_gnt_idx;
  logic [N_TELLER-1:0] w_gnt_oh;
  logic                w_dispatch;
  logic                w_push;
  logic                w_reject;
  logic [N_TELLER-1:0] w_busy_n;
  logic [TICKET_W-1:0] w_head;
  logic [CNT_W-1:0]    w_count;

  assign w_arrive_ev = bus.arrive & ~r_arrive_d;
  assign w_done_ev   = bus.done & ~r_done_d;
  assign w_elig      = bus.teller_en & ~r_busy;

  ticket_fifo #(
    .DEPTH (QDEPTH),
    .W     (TICKET_W)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_dispatch),
    .i_data  (r_next_tkt),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_c0      = next_teller(r_last);
    w_c1      = next_teller(w_c0);
    w_c2      = next_teller(w_c1);
    if (w_elig[w_c0]) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = w_c0;
    end else if (w_elig[w_c1]) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = w_c1;
    end else if (w_elig[w_c2]) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = w_c2;
    end

    w_dispatch = (r_state != Q_EMPTY) && w_gnt_vld;
    w_gnt_oh   = w_dispatch ? (N_TELLER'(1) << w_gnt_idx) : '0;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    w_push     = w_arrive_ev && ((r_state != Q_FULL) || w_dispatch);
    w_reject   = w_arrive_ev && (r_state == Q_FULL) && !w_dispatch;
    w_busy_n   = (r_busy & ~w_done_ev) | w_gnt_oh;

    w_state_n = r_state;
    case (r_state)
      Q_EMPTY:  if (w_push) w_state_n = Q_ACTIVE;
      Q_ACTIVE: begin
        if (w_push && !w_dispatch && (w_count == CNT_W'(QDEPTH - 1)))
          w_state_n = Q_FULL;
        else if (!w_push && w_dispatch && (w_count == CNT_W'(1)))
          w_state_n = Q_EMPTY;
      end
      Q_FULL:   if (w_dispatch && !w_push) w_state_n = Q_ACTIVE;
      default:  w_state_n = Q_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= Q_EMPTY;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_empty <= (w_state_n == Q_EMPTY);
      r_full  <= (w_state_n == Q_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_arrive_d    <= 1'b0;
      r_done_d      <= '0;
      r_busy        <= '0;
      r_last        <= 2'd2;
      r_call_valid  <= 1'b0;
      r_call_teller <= '0;
      r_call_ticket <= '0;
      r_reject      <= 1'b0;
      r_next_tkt    <= TICKET_W'(1);
      r_est         <= '0;
    end else begin
      r_arrive_d   <= bus.arrive;
      r_done_d     <= bus.done;
      r_busy       <= w_busy_n;
      r_call_valid <= w_dispatch;
      r_reject     <= w_reject;
      r_est        <= est_calc(w_count, bus.teller_en);
      if (w_dispatch) begin
        r_call_teller <= w_gnt_idx;
        r_call_ticket <= w_head;
        r_last        <= w_gnt_idx;
      end
      if (w_push)
        r_next_tkt <= (r_next_tkt == '1) ? TICKET_W'(1) : r_next_tkt + 1'b1;
    end
  end

  assign bus.q_count     = w_count;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.busy        = r_busy;
  assign bus.call_valid  = r_call_valid;
  assign bus.call_teller = r_call_teller;
  assign bus.call_ticket = r_call_ticket;
  assign bus.reject      = r_reject;
  assign bus.est_wait    = r_est;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Randomized scoreboard bench for teller_dispatcher against a queue-level reference model.
module tb_teller_dispatcher;

  typedef struct {
    int teller;
    int ticket;
    int cyc;
  } call_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;

  call_t    exp_q[$];
  int       mq[$];
  bit [2:0] mbusy;
  int       mlast;
  int       mnext;
  bit       marr;
  bit [2:0] mdone;
  int       mest;
  bit       mrej;

  teller_dispatcher_if #(.TICKET_W(4)) bus ();

  teller_dispatcher #(
    .QDEPTH   (7),
    .TICKET_W (4)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented call against the oldest expected call.
  always @(posedge clk) begin
    call_t e;
    #1;
    if (bus.call_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL call_unexpected: got teller %0d ticket %0d, expected no call (cycle %0d)",
                 bus.call_teller, bus.call_ticket, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("call_teller", 32'(bus.call_teller), e.teller);
        chk("call_ticket", 32'(bus.call_ticket), e.ticket);
        chk("call_cycle", cyc, e.cyc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL call_missing: got no call, expected teller %0d ticket %0d (cycle %0d)",
               e.teller, e.ticket, cyc);
    end
  end

  // One clock of stimulus; the model predicts the effect of the coming edge.
  task automatic step(input bit a, input bit [2:0] d, input bit [2:0] en, input bit rn);
    int       sz;
    int       n;
    int       g;
    int       c;
    bit [2:0] dev;
    bit [2:0] elig;
    bit       ev;
    bit       acc;
    call_t    e;
    @(negedge clk);
    bus.arrive    = a;
    bus.done      = d;
    bus.teller_en = en;
    rst           = rn;
    if (!rn) begin
      mq.delete();
      mbusy = '0;
      mlast = 2;
      mnext = 1;
      marr  = 1'b0;
      mdone = '0;
      mest  = 0;
      mrej  = 1'b0;
    end else begin
      sz   = mq.size();
      dev  = d & ~mdone;
      elig = en & ~mbusy;
      g    = -1;
      if (sz > 0) begin
        for (int k = 1; k <= 3; k++) begin
          c = (mlast + k) % 3;
          if (g < 0 && elig[c]) g = c;
        end
      end
      if (g >= 0) begin
        e.teller = g;
        e.ticket = mq.pop_front();
        e.cyc    = cyc + 1;
        exp_q.push_back(e);
        mlast = g;
      end
      ev   = a && !marr;
      acc  = ev && (sz < 7 || g >= 0);
      mrej = ev && !acc;
      if (acc) begin
        mq.push_back(mnext);
        mnext = mnext % 15 + 1;
      end
      n    = $countones(en);
      mest = (n == 0) ? ((sz == 0) ? 0 : 31) : sz * (4 - n);
      mbusy = mbusy & ~dev;
      if (g >= 0) mbusy[g] = 1'b1;
      marr  = a;
      mdone = d;
    end
    @(posedge clk);
    #1;
    chk("q_count", 32'(bus.q_count), mq.size());
    chk("full", 32'(bus.full), (mq.size() == 7) ? 1 : 0);
    chk("empty", 32'(bus.empty), (mq.size() == 0) ? 1 : 0);
    chk("busy", 32'(bus.busy), 32'(mbusy));
    chk("reject", 32'(bus.reject), 32'(mrej));
    chk("est_wait", 32'(bus.est_wait), mest);
  endtask

  task automatic pulses(input int cnt, input bit [2:0] en);
    for (int i = 0; i < cnt; i++) begin
      step(1'b1, 3'b000, en, 1'b1);
      step(1'b0, 3'b000, en, 1'b1);
    end
  endtask

  initial begin
    bit [2:0] ren;
    bit [2:0] rd;
    bit       ra;
    bit       rrn;
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b0;
    bus.arrive    = 1'b0;
    bus.done      = 3'b000;
    bus.teller_en = 3'b000;

    // Reset state
    step(1'b0, 3'b000, 3'b000, 1'b0);
    step(1'b0, 3'b000, 3'b000, 1'b0);
    chk("rst_call_teller", 32'(bus.call_teller), 0);
    chk("rst_call_ticket", 32'(bus.call_ticket), 0);
    chk("rst_call_valid", 32'(bus.call_valid), 0);

    // Single teller: first call one cycle after arrival, then the queue builds
    pulses(3, 3'b001);
    chk("one_teller_qcount", 32'(bus.q_count), 2);
    chk("one_teller_est", 32'(bus.est_wait), 6);

    // No tellers: fill, reject the eighth, then arrival together with a dispatch
    step(1'b0, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'b000, 3'b000, 1'b1);
      if (i == 7) chk("eighth_reject", 32'(bus.reject), 1);
      step(1'b0, 3'b000, 3'b000, 1'b1);
    end
    chk("fill_qcount", 32'(bus.q_count), 7);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_est", 32'(bus.est_wait), 31);
    step(1'b1, 3'b000, 3'b001, 1'b1);
    chk("full_swap_qcount", 32'(bus.q_count), 7);
    chk("full_swap_full", 32'(bus.full), 1);
    chk("full_swap_reject", 32'(bus.reject), 0);
    step(1'b0, 3'b000, 3'b001, 1'b1);

    // Three tellers: back-to-back grants 0,1,2, fourth waits for a done
    step(1'b0, 3'b000, 3'b000, 1'b0);
    pulses(4, 3'b000);
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 3'b111, 1'b1);
    step(1'b0, 3'b010, 3'b111, 1'b1);
    step(1'b0, 3'b010, 3'b111, 1'b1);
    chk("freed_teller", 32'(bus.call_teller), 1);
    step(1'b0, 3'b000, 3'b111, 1'b1);

    // Sixteen accept/dispatch rounds: ticket numbers wrap 15 -> 1
    step(1'b0, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 3'b000, 3'b111, 1'b1);
      step(1'b0, 3'b111, 3'b111, 1'b1);
    end
    chk("wrap_ticket", 32'(bus.call_ticket), 1);

    // Mid-operation reset with q_count=5, busy=011
    step(1'b0, 3'b000, 3'b000, 1'b0);
    pulses(7, 3'b011);
    chk("pre_rst_qcount", 32'(bus.q_count), 5);
    chk("pre_rst_busy", 32'(bus.busy), 3);
    step(1'b0, 3'b000, 3'b011, 1'b0);
    chk("mid_rst_qcount", 32'(bus.q_count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    pulses(1, 3'b011);
    chk("post_rst_ticket", 32'(bus.call_ticket), 1);

    // Randomized traffic
    ren = 3'b011;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) ren = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 1) == 1);
      rd  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rrn = ($urandom_range(0, 149) != 0);
      step(ra, rd, ren, rrn);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 3'b000, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
